alu_slice: RTL and testbench

Parametrised successor to the four-bit bit-slice datapath: a single-chip, WIDTH-bit ALU slice. It has a REGS-entry two-port register file, a Q register, Am2901-compatible 9-bit microinstruction decoding, and shift ports. New relative to the four-bit slice: async reset of all state, defined logic-op flags, and an optional iterative unsigned multiply engine. It sits in the micro-BESM datapath under the microsequencer, which drives I/Aadd/Badd every cycle.

---
 rtl/alu_slice.sv | 136 +++++++++++++
 tb/tb_alu_slice.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_slice.sv
// alu_slice: WIDTH-bit Am2901-style ALU slice with register file, Q register and shift ports.
// Defining ALU_SLICE_MUL_EN adds the iterative unsigned multiply engine (mul_start/busy/done).
module alu_slice #(
   parameter int WIDTH = 16,
   parameter int REGS = 16,
   localparam int AW = $clog2(REGS)
) (
   input  logic             clk,
   input  logic             nRESET,
`ifdef ALU_SLICE_MUL_EN
   input  logic             mul_start,
   output logic             busy,
   output logic             done,
`endif
   input  logic [8:0]       I,
   input  logic [AW-1:0]    Aadd,
   input  logic [AW-1:0]    Badd,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Y,
   input  logic             nOE,
   input  logic             C0,
   input  logic             RAM0,
   input  logic             RAMN,
   input  logic             Q0,
   input  logic             QN,
   output logic             oRAM0,
   output logic             oRAMN,
   output logic             oQ0,
   output logic             oQN,
   output logic             C4,
   output logic             nG,
   output logic             nP,
   output logic             OVR,
   output logic             FN,
   output logic             FZ
);
   logic [WIDTH-1:0] ram [REGS];
   logic [WIDTH-1:0] q, a, b, r, s, ra, sa, f, g, p, ram_d, q_d, acc, mq;
   logic [WIDTH:0] sum;
   logic [2:0] src, fn, dst;
   logic [AW-1:0] bsel;
   logic arith, gen, ram_we, q_we, lock, mul_wr, mul_run;

   assign {dst, fn, src} = I;
   assign a = ram[Aadd];
   assign b = ram[Badd];
   assign r = src[2] ? (src[1:0] == 2'b00 ? '0 : D) : (src[1] ? '0 : a);
   assign s = src[2] ? (src[1] ? (src[0] ? '0 : q) : a) : (src[0] ? b : q);
   assign ra = fn == 3'b001 ? ~r : r;
   assign sa = fn == 3'b010 ? ~s : s;
   assign sum = {1'b0, ra} + {1'b0, sa} + (WIDTH + 1)'(C0);
   assign arith = !fn[2] && fn[1:0] != 2'b11;
   assign f = arith ? sum[WIDTH-1:0] :
              fn == 3'b011 ? r | s :
              fn == 3'b100 ? r & s :
              fn == 3'b101 ? ~r & s :
              fn == 3'b110 ? r ^ s : ~(r ^ s);
   assign C4 = arith & sum[WIDTH];
   // carry into the MSB is recovered from the MSB sum bit
   assign OVR = arith & (ra[WIDTH-1] ^ sa[WIDTH-1] ^ sum[WIDTH-1] ^ sum[WIDTH]);
   assign g = ra & sa;
   assign p = ra | sa;
   always_comb begin
      gen = 1'b0;
      for (int i = 0; i < WIDTH; i++) gen = g[i] | (p[i] & gen);
   end
   assign nG = ~gen;
   assign nP = ~&p;
   assign FN = f[WIDTH-1];
   assign FZ = f == '0;
   assign Y = nOE ? 'z : (dst == 3'b010 ? a : f);
   assign ram_we = dst[2] | dst[1];
   assign ram_d = !dst[2] ? f : !dst[1] ? {RAMN, f[WIDTH-1:1]} : {f[WIDTH-2:0], RAM0};
   assign q_we = !dst[0] && dst != 3'b010;
   assign q_d = !dst[2] ? f : !dst[1] ? {QN, q[WIDTH-1:1]} : {q[WIDTH-2:0], Q0};
   assign oRAM0 = dst[2:1] == 2'b10 && f[0];
   assign oQ0 = dst[2:1] == 2'b10 && q[0];
   assign oRAMN = dst[2:1] == 2'b11 && f[WIDTH-1];
   assign oQN = dst[2:1] == 2'b11 && q[WIDTH-1];

`ifdef ALU_SLICE_MUL_EN
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
   localparam int CW = $clog2(WIDTH + 1);
   logic [1:0] state;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] m;
   logic [WIDTH:0] psum;
   assign psum = {1'b0, acc} + {1'b0, {WIDTH{q[0]}} & m};
   // Q doubles as the shift register: multiplier out of the bottom, product low half in at the top
   assign mq = {psum[0], q[WIDTH-1:1]};
   assign lock = state != IDLE;
   assign mul_run = state == RUN;
   assign mul_wr = state == DONE;
   assign busy = lock;
   assign done = mul_wr;
   always_ff @(posedge clk or negedge nRESET)
      if (!nRESET) begin
         state <= IDLE;
         cnt <= '0;
         m <= '0;
         acc <= '0;
         bsel <= '0;
      end else if (state == IDLE) begin
         if (mul_start) begin
            state <= RUN;
            m <= a;
            bsel <= Badd;
            acc <= '0;
            cnt <= CW'(WIDTH);
         end
      end else if (state == RUN) begin
         acc <= psum[WIDTH:1];
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) state <= DONE;
      end else
         state <= IDLE;
`else
   assign lock = 1'b0;
   assign mul_run = 1'b0;
   assign mul_wr = 1'b0;
   assign acc = '0;
   assign bsel = '0;
   assign mq = '0;
`endif

   always_ff @(posedge clk or negedge nRESET)
      if (!nRESET) begin
         for (int i = 0; i < REGS; i++) ram[i] <= '0;
         q <= '0;
      end else begin
         if (mul_wr) ram[bsel] <= acc;
         else if (ram_we && !lock) ram[Badd] <= ram_d;
         if (mul_run) q <= mq;
         else if (q_we && !lock) q <= q_d;
      end
endmodule

// File: tb/tb_alu_slice.sv
// tb_alu_slice: WIDTH=8 directed and random checks of alu_slice against an arithmetic reference model.
// Multiply checks are compiled when ALU_SLICE_MUL_EN is defined.
module tb_alu_slice;
   localparam int W = 8;
   logic clk = 1'b0, nRESET = 1'b0;
   logic [8:0] I = '0;
   logic [3:0] Aadd = '0, Badd = '0;
   logic [W-1:0] D = '0;
   logic nOE = 1'b0, C0 = 1'b0, RAM0 = 1'b0, RAMN = 1'b0, Q0 = 1'b0, QN = 1'b0;
   wire [W-1:0] Y;
   logic oRAM0, oRAMN, oQ0, oQN, C4, nG, nP, OVR, FN, FZ;
`ifdef ALU_SLICE_MUL_EN
   logic mul_start = 1'b0;
   logic busy, done;
   int nbusy, ndone, done_at, prod, seen_done;
   logic [W-1:0] mv, qv;
`endif
   int checks = 0, errors = 0;
   int mram [16];
   int mq = 0;
   int e_y, e_c4, e_ovr, e_ng, e_np, e_fn, e_fz, e_or0, e_orn, e_oq0, e_oqn, e_ramw, e_ramd, e_qw, e_qd;

   alu_slice #(.WIDTH(W), .REGS(16)) dut (
      .clk(clk), .nRESET(nRESET),
`ifdef ALU_SLICE_MUL_EN
      .mul_start(mul_start), .busy(busy), .done(done),
`endif
      .I(I), .Aadd(Aadd), .Badd(Badd), .D(D), .Y(Y), .nOE(nOE), .C0(C0),
      .RAM0(RAM0), .RAMN(RAMN), .Q0(Q0), .QN(QN),
      .oRAM0(oRAM0), .oRAMN(oRAMN), .oQ0(oQ0), .oQN(oQN),
      .C4(C4), .nG(nG), .nP(nP), .OVR(OVR), .FN(FN), .FZ(FZ)
   );

   always #5 clk = ~clk;

   function automatic int sx(int x);
      return x >= 128 ? x - 256 : x;
   endfunction

   function automatic void eval();
      int a, b, r, s, ri, si, t, st, f, src, fn, dst;
      a = mram[Aadd];
      b = mram[Badd];
      src = int'(I[2:0]);
      fn = int'(I[5:3]);
      dst = int'(I[8:6]);
      case (src)
         0: begin r = a; s = mq; end
         1: begin r = a; s = b; end
         2: begin r = 0; s = mq; end
         3: begin r = 0; s = b; end
         4: begin r = 0; s = a; end
         5: begin r = int'(D); s = a; end
         6: begin r = int'(D); s = mq; end
         default: begin r = int'(D); s = 0; end
      endcase
      ri = fn == 1 ? 255 - r : r;
      si = fn == 2 ? 255 - s : s;
      t = ri + si + int'(C0);
      st = sx(ri) + sx(si) + int'(C0);
      case (fn)
         0, 1, 2: f = t % 256;
         3: f = r | s;
         4: f = r & s;
         5: f = (255 - r) & s;
         6: f = r ^ s;
         default: f = 255 - (r ^ s);
      endcase
      e_c4 = (fn < 3 && t > 255) ? 1 : 0;
      e_ovr = (fn < 3 && (st > 127 || st < -128)) ? 1 : 0;
      e_ng = (ri + si > 255) ? 0 : 1;
      e_np = ((ri | si) == 255) ? 0 : 1;
      e_fn = f / 128;
      e_fz = f == 0 ? 1 : 0;
      e_y = dst == 2 ? a : f;
      e_ramw = dst >= 2 ? 1 : 0;
      e_ramd = dst < 4 ? f : dst < 6 ? f / 2 + 128 * int'(RAMN) : (f * 2) % 256 + int'(RAM0);
      e_qw = (dst == 0 || dst == 4 || dst == 6) ? 1 : 0;
      e_qd = dst == 0 ? f : dst == 4 ? mq / 2 + 128 * int'(QN) : (mq * 2) % 256 + int'(Q0);
      e_or0 = (dst == 4 || dst == 5) ? f % 2 : 0;
      e_oq0 = (dst == 4 || dst == 5) ? mq % 2 : 0;
      e_orn = dst >= 6 ? f / 128 : 0;
      e_oqn = dst >= 6 ? mq / 128 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [8:0] i, input logic [3:0] aa, input logic [3:0] bb,
                        input logic [W-1:0] dd, input logic c);
      I = i;
      Aadd = aa;
      Badd = bb;
      D = dd;
      C0 = c;
      #1;
      eval();
      chk("Y", 32'(Y), e_y);
      chk("C4", 32'(C4), e_c4);
      chk("OVR", 32'(OVR), e_ovr);
      chk("nG", 32'(nG), e_ng);
      chk("nP", 32'(nP), e_np);
      chk("FN", 32'(FN), e_fn);
      chk("FZ", 32'(FZ), e_fz);
      chk("oRAM0", 32'(oRAM0), e_or0);
      chk("oRAMN", 32'(oRAMN), e_orn);
      chk("oQ0", 32'(oQ0), e_oq0);
      chk("oQN", 32'(oQN), e_oqn);
   endtask

   task automatic tick();
      @(posedge clk);
      if (nRESET) begin
         if (e_ramw != 0) mram[Badd] = e_ramd;
         if (e_qw != 0) mq = e_qd;
      end
      @(negedge clk);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mram[i] = 0;
      mq = 0;
   endtask

   initial begin
      @(negedge clk);
      drive(9'b001_000_010, 4'd0, 4'd0, 8'h00, 1'b0);
      chk("rst_q", 32'(Y), 32'h0);
      chk("rst_fz", 32'(FZ), 32'h1);
      tick();
      nRESET = 1'b1;
      @(negedge clk);
      drive(9'b001_000_111, 4'd0, 4'd0, 8'h7F, 1'b1);
      chk("add_y", 32'(Y), 32'h80);
      chk("add_ovr", 32'(OVR), 32'h1);
      chk("add_c4", 32'(C4), 32'h0);
      chk("add_fn", 32'(FN), 32'h1);
      chk("add_fz", 32'(FZ), 32'h0);
      tick();
      drive(9'b011_000_111, 4'd0, 4'd3, 8'h0F, 1'b0);
      tick();
      drive(9'b011_000_111, 4'd0, 4'd5, 8'hF0, 1'b0);
      tick();
      drive(9'b001_011_001, 4'd3, 4'd5, 8'h00, 1'b0);
      chk("or_y", 32'(Y), 32'hFF);
      chk("or_c4", 32'(C4), 32'h0);
      chk("or_ovr", 32'(OVR), 32'h0);
      chk("or_fz", 32'(FZ), 32'h0);
      tick();
      drive(9'b011_000_111, 4'd0, 4'd1, 8'h05, 1'b0);
      tick();
      drive(9'b001_001_001, 4'd1, 4'd1, 8'h00, 1'b1);
      chk("sub_y", 32'(Y), 32'h0);
      chk("sub_fz", 32'(FZ), 32'h1);
      chk("sub_c4", 32'(C4), 32'h1);
      tick();
      drive(9'b000_000_111, 4'd0, 4'd0, 8'h02, 1'b0);
      tick();
      RAMN = 1'b1;
      QN = 1'b0;
      drive(9'b100_000_111, 4'd0, 4'd6, 8'h81, 1'b0);
      chk("shr_oram0", 32'(oRAM0), 32'h1);
      chk("shr_oq0", 32'(oQ0), 32'h0);
      tick();
      drive(9'b001_000_100, 4'd6, 4'd0, 8'h00, 1'b0);
      chk("shr_ram", 32'(Y), 32'hC0);
      tick();
      drive(9'b001_000_010, 4'd0, 4'd0, 8'h00, 1'b0);
      chk("shr_q", 32'(Y), 32'h01);
      tick();
      drive(9'b010_000_111, 4'd7, 4'd7, 8'h3C, 1'b0);
      tick();
      drive(9'b010_000_111, 4'd7, 4'd7, 8'h11, 1'b0);
      chk("rd_old", 32'(Y), 32'h3C);
      tick();
      for (int n = 0; n < 300; n++) begin
         RAM0 = 1'($urandom);
         RAMN = 1'($urandom);
         Q0 = 1'($urandom);
         QN = 1'($urandom);
         drive(9'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), 1'($urandom));
         tick();
      end
      nRESET = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      nRESET = 1'b1;
      for (int k = 0; k < 16; k++) begin
         drive(9'b001_000_100, 4'(k), 4'd0, 8'h00, 1'b0);
         tick();
      end
      drive(9'b001_000_010, 4'd0, 4'd0, 8'h00, 1'b0);
      tick();
`ifdef ALU_SLICE_MUL_EN
      drive(9'b000_000_111, 4'd0, 4'd0, 8'hFF, 1'b0);
      tick();
      drive(9'b011_000_111, 4'd0, 4'd2, 8'hFF, 1'b0);
      tick();
      drive(9'b001_000_111, 4'd2, 4'd4, 8'h00, 1'b0);
      mul_start = 1'b1;
      tick();
      mul_start = 1'b0;
      nbusy = 0;
      ndone = 0;
      done_at = 0;
      I = 9'b100_000_111;
      D = 8'h55;
      for (int c = 1; c <= 12; c++) begin
         #1;
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            done_at = c;
         end
         if (busy) chk("busy_y", 32'(Y), 32'h55);
         else I = 9'b001_000_111;
         @(posedge clk);
         @(negedge clk);
      end
      chk("mul_busy_cycles", nbusy, 9);
      chk("mul_done_count", ndone, 1);
      chk("mul_done_cycle", done_at, 9);
      prod = 255 * 255;
      mram[4] = prod / 256;
      mq = prod % 256;
      drive(9'b001_000_100, 4'd4, 4'd0, 8'h00, 1'b0);
      chk("mul_hi", 32'(Y), 32'hFE);
      tick();
      drive(9'b001_000_010, 4'd0, 4'd0, 8'h00, 1'b0);
      chk("mul_lo", 32'(Y), 32'h01);
      tick();
      drive(9'b000_000_111, 4'd0, 4'd0, 8'hA7, 1'b0);
      tick();
      drive(9'b011_000_111, 4'd0, 4'd2, 8'hC3, 1'b0);
      tick();
      drive(9'b001_000_111, 4'd2, 4'd4, 8'h00, 1'b0);
      mul_start = 1'b1;
      tick();
      mul_start = 1'b0;
      seen_done = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) seen_done++;
      end
      nRESET = 1'b0;
      #1;
      model_reset();
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_done", 32'(done), 32'h0);
      @(negedge clk);
      nRESET = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) seen_done++;
      end
      chk("abort_no_done", seen_done, 0);
      drive(9'b001_000_100, 4'd4, 4'd0, 8'h00, 1'b0);
      chk("abort_ram4", 32'(Y), 32'h0);
      tick();
      drive(9'b001_000_010, 4'd0, 4'd0, 8'h00, 1'b0);
      chk("abort_q", 32'(Y), 32'h0);
      tick();
      mv = 8'($urandom_range(1, 255));
      qv = 8'($urandom_range(1, 255));
      drive(9'b000_000_111, 4'd0, 4'd0, qv, 1'b0);
      tick();
      drive(9'b011_000_111, 4'd0, 4'd2, mv, 1'b0);
      tick();
      drive(9'b001_000_111, 4'd2, 4'd4, 8'h00, 1'b0);
      mul_start = 1'b1;
      tick();
      mul_start = 1'b0;
      nbusy = 0;
      for (int c = 0; c < 20 && busy; c++) begin
         nbusy++;
         @(posedge clk);
         @(negedge clk);
      end
      chk("mul2_finished", 32'(busy), 32'h0);
      chk("mul2_busy_cycles", nbusy, 9);
      prod = int'(mv) * int'(qv);
      mram[4] = prod / 256;
      mq = prod % 256;
      drive(9'b001_000_100, 4'd4, 4'd0, 8'h00, 1'b0);
      tick();
      drive(9'b001_000_010, 4'd0, 4'd0, 8'h00, 1'b0);
      tick();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
